simon_key_sched_ctrl: RTL
=========================

SIMON_KEY_SCHED_CTRL -- requirements
Module: simon_key_sched_ctrl

Interface
REQ-001 SHALL have parameter Z_IDX, default 0: z-sequence select, 0..4.
REQ-002 SHALL have parameter KEY_WORDS, default 4: key words m, 2..4.
REQ-003 SHALL have parameter ROUNDS, default 32: round count T, KEY_WORDS+1..72.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port key_in_vld, input, 1: master key presented to the datapath.
REQ-007 SHALL have port key_in_rdy, output, 1: controller can accept a key.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of the current schedule.
REQ-009 SHALL have port ks_load, output, 1: datapath loads the master key words.
REQ-010 SHALL have port ks_step, output, 1: datapath advances one key-expansion step.
REQ-011 SHALL have port ks_round, output, 7: index of the current subkey.
REQ-012 SHALL have port ks_zbit, output, 1: z-sequence bit for the current step.
REQ-013 SHALL have port subkey_out_vld, output, 1: datapath subkey valid to the consumer.
REQ-014 SHALL have port subkey_out_rdy, input, 1: consumer accepts the subkey.
REQ-015 SHALL have port sched_done, output, 1: one-cycle pulse after the last subkey.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL drive key_in_rdy=1 only in IDLE.
REQ-018 SHALL drive ks_load=key_in_vld&key_in_rdy combinationally, then enter RUN with round=0.
REQ-019 SHALL assert subkey_out_vld exactly while in RUN, so the first subkey is valid the cycle after the key is accepted.
REQ-020 SHALL complete a handshake when subkey_out_vld&subkey_out_rdy; with no handshake, round, ks_round and ks_zbit hold.
REQ-021 SHALL, on a handshake with round<ROUNDS-1, drive ks_step=1 (combinational) and increment round.
REQ-022 SHALL, on a handshake with round=ROUNDS-1, drive ks_step=0 and enter DONE.
REQ-023 SHALL, in DONE, assert sched_done for exactly one cycle and return to IDLE; key_in_rdy=0 in DONE.
REQ-024 SHALL drive ks_round as the round register (0..ROUNDS-1).
REQ-025 SHALL, for round<KEY_WORDS, drive ks_zbit=0 (the subkey is a raw key word).
REQ-026 SHALL, otherwise, drive ks_zbit=z[61-j] with j=(round-KEY_WORDS) mod 62, so that z bit 61 (MSB of the literal) is consumed first; j SHALL be a wrapping 6-bit counter, not a divider.
REQ-027 SHALL, when abort=1 in RUN or DONE, go to IDLE next cycle with ks_step=0 and no sched_done pulse; abort wins over a simultaneous handshake.
REQ-028 SHALL ignore abort in IDLE, so ks_load still fires.
REQ-029 SHALL ignore key_in_vld outside IDLE; no ks_load is issued.
REQ-030 SHALL accept back-to-back keys: a new key is accepted in the IDLE cycle following DONE.

Reset
REQ-031 SHALL, when rst=0, asynchronously force state=IDLE, round=0 and j=0.
REQ-032 SHALL, during reset, hold key_in_rdy=0, ks_load=0, ks_step=0, subkey_out_vld=0, sched_done=0, ks_round=0 and ks_zbit=0.
REQ-033 SHALL discard any schedule in progress when reset is asserted mid-RUN, with no sched_done; key_in_rdy rises the first cycle after deassertion.

Structure
REQ-034 SHALL place in a shared package simon_pkg: the five 62-bit z constants Z0..Z4, the FSM state enum and the round-width localparam (7).
REQ-035 SHALL reject out-of-range Z_IDX, KEY_WORDS or ROUNDS with an elaboration-time error.
REQ-036 SHALL contain one natural sub-module, simon_zseq_ptr (the wrapping j counter plus z-bit select), and no datapath.

Verification
REQ-037 SHALL cover the default run: Z_IDX=0, M=4, T=32, key accepted, rdy held 1 -> subkey_out_vld for 32 cycles; ks_round 0..31; ks_step on rounds 0..30; ks_zbit 0,0,0,0 then 1,1,1,1,1,0; sched_done pulse 1 cycle after round 31.
REQ-038 SHALL cover backpressure: subkey_out_rdy toggled every other cycle -> each round held 2 cycles, 32 handshakes total, ks_step count 31.
REQ-039 SHALL cover z wrap: Z_IDX=4, M=4, T=72 -> the ks_zbit sequence over rounds 4..65 equals Z4 MSB-first, and round 66 repeats bit 61.
REQ-040 SHALL cover abort on the last handshake: abort with round=31 -> IDLE next cycle, no sched_done, key_in_rdy=1.
REQ-041 SHALL cover reset mid-run: rst=0 at round 10 -> all outputs 0 immediately; after release, key_in_rdy=1 and a new key restarts at round 0.
REQ-042 SHALL cover key during RUN: key_in_vld=1 throughout RUN -> no ks_load until IDLE, then ks_load for exactly one cycle.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants and types for the SIMON key-schedule controller:
// the five z sequences (MSB of each literal is consumed first) and the FSM state type.
package simon_pkg;

    localparam int ROUND_W = 7;

    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic logic [61:0] z_select(input int idx);
        case (idx)
            1:       return Z1;
            2:       return Z2;
            3:       return Z3;
            4:       return Z4;
            default: return Z0;
        endcase
    endfunction

endpackage

// File: rtl/simon_zseq_ptr.sv
// Position inside the 62-bit z sequence: a wrapping 0..61 counter and the bit it selects.
module simon_zseq_ptr
    import simon_pkg::*;
#(
    parameter int Z_IDX = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic zbit
);

    localparam logic [61:0] Z_SEQ = z_select(Z_IDX);

    logic [5:0] j_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j_reg <= 6'd0;
        end else if (clr) begin
            j_reg <= 6'd0;
        end else if (adv) begin
            j_reg <= (j_reg == 6'd61) ? 6'd0 : j_reg + 6'd1;
        end
    end

    // j=0 picks bit 61, so the sequence streams out MSB-first.
    assign zbit = Z_SEQ[6'd61 - j_reg];

endmodule

// File: rtl/simon_key_sched_ctrl.sv
// Control FSM for a SIMON key-expansion datapath: accepts a master key, then
// hands out ROUNDS subkeys under valid/ready flow control and pulses sched_done.
module simon_key_sched_ctrl
    import simon_pkg::*;
#(
    parameter int Z_IDX     = 0,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key_in_vld,
    output logic                 key_in_rdy,
    input  logic                 abort,
    output logic                 ks_load,
    output logic                 ks_step,
    output logic [ROUND_W-1:0]   ks_round,
    output logic                 ks_zbit,
    output logic                 subkey_out_vld,
    input  logic                 subkey_out_rdy,
    output logic                 sched_done
);

    if (Z_IDX < 0 || Z_IDX > 4) begin : g_bad_z_idx
        $error("simon_key_sched_ctrl: Z_IDX must be 0..4");
    end
    if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key_words
        $error("simon_key_sched_ctrl: KEY_WORDS must be 2..4");
    end
    if (ROUNDS < KEY_WORDS + 1 || ROUNDS > 72) begin : g_bad_rounds
        $error("simon_key_sched_ctrl: ROUNDS must be KEY_WORDS+1..72");
    end

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);
    localparam logic [ROUND_W-1:0] KW         = ROUND_W'(KEY_WORDS);

    sched_state_t         state_reg;
    logic [ROUND_W-1:0]   round_reg;
    logic                 rdy_reg;
    logic                 vld_reg;
    logic                 done_reg;
    logic                 handshake;
    logic                 last_round;
    logic                 z_bit;

    assign handshake  = vld_reg & subkey_out_rdy;
    assign last_round = (round_reg == LAST_ROUND);

    assign key_in_rdy     = rdy_reg;
    assign ks_load        = key_in_vld & rdy_reg;
    assign ks_step        = handshake & ~abort & ~last_round;
    assign subkey_out_vld = vld_reg;
    // An abort landing on the DONE cycle suppresses the completion pulse.
    assign sched_done     = done_reg & ~abort;
    assign ks_round       = round_reg;
    assign ks_zbit        = (round_reg < KW) ? 1'b0 : z_bit;

    simon_zseq_ptr #(
        .Z_IDX (Z_IDX)
    ) u_zseq_ptr (
        .clk  (clk),
        .rst  (rst),
        .clr  (ks_load),
        .adv  (ks_step & (round_reg >= KW)),
        .zbit (z_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            round_reg <= '0;
            rdy_reg   <= 1'b0;
            vld_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rdy_reg <= 1'b1;
                    if (ks_load) begin
                        state_reg <= RUN;
                        round_reg <= '0;
                        rdy_reg   <= 1'b0;
                        vld_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        round_reg <= '0;
                        vld_reg   <= 1'b0;
                        rdy_reg   <= 1'b1;
                    end else if (handshake) begin
                        if (last_round) begin
                            state_reg <= DONE;
                            vld_reg   <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            round_reg <= round_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    round_reg <= '0;
                    done_reg  <= 1'b0;
                    rdy_reg   <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    round_reg <= '0;
                    vld_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    rdy_reg   <= 1'b0;
                end
            endcase
        end
    end

endmodule
